// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Controller-side bundle: operation request, MTHI/MTLO writes, status and HI/LO read-out.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// Magnitude datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   mag_a,
  input  logic [WIDTH-1:0]   mag_b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opd_reg;
  logic               div_reg;
  logic [CW-1:0]      count_reg;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;

  // Multiply: lower half starts as the multiplier and is consumed LSB-first.
  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opd_reg} : '0);
    shifted  = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    diff     = shifted - {1'b0, opd_reg};
    acc_next = acc_reg;
    if (step) begin
      if (!div_reg)
        acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
      else if (diff[WIDTH])
        acc_next = {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg   <= '0;
      opd_reg   <= '0;
      div_reg   <= 1'b0;
      count_reg <= '0;
    end else if (load) begin
      acc_reg   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      opd_reg   <= is_div ? mag_b : mag_a;
      div_reg   <= is_div;
      count_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      if (step)
        count_reg <= count_reg + 1'b1;
    end
  end

  assign acc  = acc_reg;
  assign last = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and a start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  state_e             state_reg, state_next;
  logic               load, step, last;
  logic [2*WIDTH-1:0] acc;

  logic               div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg;

  logic               signed_op, is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign sign_a    = signed_op & bus.a[WIDTH-1];
  assign sign_b    = signed_op & bus.b[WIDTH-1];
  assign mag_a     = sign_a ? -bus.a : bus.a;
  assign mag_b     = sign_b ? -bus.b : bus.b;

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .step    (step),
    .is_div  (is_div),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc     (acc),
    .last    (last)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last)
          state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prod = neg_q_reg ? -acc : acc;
  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  // Divide-by-zero leaves |a| in the remainder, so sign correction restores the original a in HI.
  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (state_reg == FIX) begin
      if (div_reg) begin
        lo_next = div_zero_reg ? '1 : (neg_q_reg ? -quot : quot);
        hi_next = neg_r_reg ? -rem : rem;
      end else begin
        {hi_next, lo_next} = prod;
      end
    end else if (state_reg == IDLE && !bus.start) begin
      if (bus.hi_we) hi_next = bus.wd;
      if (bus.lo_we) lo_next = bus.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      div_reg      <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= (state_reg == FIX);
      if (load) begin
        div_reg      <= is_div;
        neg_q_reg    <= sign_a ^ sign_b;
        neg_r_reg    <= sign_a;
        div_zero_reg <= (bus.b == '0);
      end
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency window, arithmetic corner cases, MTHI/MTLO and reset abort.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   dcnt;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents start in the current cycle T and returns just after the accepting edge (in T+1).
  task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.a     = '0;
    bus.b     = '0;
  endtask

  // Checks busy over T+1..T+33, then the done cycle T+34 with the new HI/LO.
  task automatic wait_result(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int nbusy;
    int ndone;
    nbusy = 0;
    ndone = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) ndone++;
    end
    chk({tag, " busy_cycles"}, nbusy, 33);
    chk({tag, " early_done"}, ndone, 0);
    @(negedge clk);
    chk({tag, " done"}, bus.done, 1);
    chk({tag, " busy_end"}, bus.busy, 0);
    chk({tag, " hi"}, bus.hi, exp_hi);
    chk({tag, " lo"}, bus.lo, exp_lo);
    $display("op %s: hi=%08h lo=%08h done=%0b", tag, bus.hi, bus.lo, bus.done);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wd    = '0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset lo", bus.lo, 0);
    reset_n = 1'b1;

    @(negedge clk);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    chk("multu_max done_one_cycle", bus.done, 0);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_result("divu_zero", 32'd100, 32'hFFFF_FFFF);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 32'h0000_0000, 32'h8000_0000);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_result("div_zero_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // start and MTHI while busy must both be ignored
    @(negedge clk);
    issue(OP_DIVU, 32'd10, 32'd3);
    dcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.hi_we = 1'b1;
        bus.wd    = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      if (bus.done === 1'b1) dcnt++;
      if (i == 34) begin
        chk("busy_ignore hi", bus.hi, 32'd1);
        chk("busy_ignore lo", bus.lo, 32'd3);
      end
    end
    chk("busy_ignore done_count", dcnt, 1);
    $display("op busy_ignore: hi=%08h lo=%08h dones=%0d", bus.hi, bus.lo, dcnt);

    bus.lo_we = 1'b1;
    bus.wd    = 32'h1234_5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo lo", bus.lo, 32'h1234_5678);
    chk("mtlo hi", bus.hi, 32'd1);
    chk("mtlo done", bus.done, 0);
    $display("op mtlo: hi=%08h lo=%08h", bus.hi, bus.lo);

    bus.hi_we = 1'b1;
    bus.wd    = 32'hCAFE_F00D;
    issue(OP_MULTU, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    chk("start_wins hi", bus.hi, 32'd1);
    chk("start_wins busy", bus.busy, 1);
    wait_result("start_wins", 32'd0, 32'd6);

    @(negedge clk);
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFE);
    for (int i = 1; i <= 9; i++) @(negedge clk);
    chk("abort busy_before", bus.busy, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort hi", bus.hi, 0);
    chk("abort lo", bus.lo, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    chk("abort hi_after", bus.hi, 0);
    chk("abort lo_after", bus.lo, 0);
    $display("op abort: hi=%08h lo=%08h dones=%0d", bus.hi, bus.lo, dcnt);

    issue(OP_MULT, 32'd7, 32'hFFFF_FFFE);
    wait_result("mult_after_reset", 32'hFFFF_FFFF, 32'hFFFF_FFF2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
